// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback source select.
// Also tracks instructions leaving WB and flags faulting loads.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc_plus4,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      mem_rdata,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [31:0]      wb_data,
  output logic             wb_valid,
  output logic             load_fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic             valid_q,     valid_d;
  logic [4:0]       rd_q,        rd_d;
  logic             reg_write_q, reg_write_d;
  logic [1:0]       wb_sel_q,    wb_sel_d;
  logic [2:0]       funct3_q,    funct3_d;
  logic [31:0]      alu_q,       alu_d;
  logic [31:0]      pc4_q,       pc4_d;
  logic [31:0]      imm_q,       imm_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic [CNT_W-1:0] retired_q,   retired_d;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        misaligned;
  logic        illegal;
  logic        fault;

  // Next stage contents: flush beats stall, stall beats capture; counter
  // advances whenever a valid occupant leaves WB.
  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    imm_d       = imm_q;
    rdata_d     = rdata_q;
    if (flush) begin
      valid_d     = 1'b0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      wb_sel_d    = '0;
      funct3_d    = '0;
      alu_d       = '0;
      pc4_d       = '0;
      imm_d       = '0;
      rdata_d     = '0;
    end else if (!stall) begin
      valid_d     = in_valid;
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
      wb_sel_d    = in_wb_sel;
      funct3_d    = in_funct3;
      alu_d       = in_alu_result;
      pc4_d       = in_pc_plus4;
      imm_d       = in_imm;
      rdata_d     = mem_rdata;
    end
    // Retirement is decided by stall alone, so flush+stall does not count.
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, (valid_q & ~stall)};
  end

  // Stage and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      rdata_q     <= '0;
      retired_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      rdata_q     <= rdata_d;
      retired_q   <= retired_d;
    end
  end

  // Byte/halfword extraction and fault detection from the held memory word.
  always_comb begin
    off = alu_q[1:0];
    case (off)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half    = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_val     = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3_q)
      3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_val = {24'h0, ld_byte};
      3'b001: begin
        ld_val     = {{16{ld_half[15]}}, ld_half};
        misaligned = off[0];
      end
      3'b101: begin
        ld_val     = {16'h0, ld_half};
        misaligned = off[0];
      end
      3'b010: begin
        ld_val     = rdata_q;
        misaligned = (off != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
    fault = valid_q & (wb_sel_q == SEL_LOAD) & (misaligned | illegal);
  end

  // Writeback source mux and register-bank qualifiers.
  always_comb begin
    case (wb_sel_q)
      SEL_ALU:  wb_data = alu_q;
      SEL_LOAD: wb_data = fault ? 32'h0 : ld_val;
      SEL_PC4:  wb_data = pc4_q;
      default:  wb_data = imm_q;
    endcase
    wb_reg_write = valid_q & reg_write_q & (rd_q != 5'd0) & ~fault;
    wb_rd        = rd_q;
    wb_valid     = valid_q;
    load_fault   = fault;
    retired      = retired_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, in_imm, mem_rdata;

  logic [4:0]  wb_rd, wb_rd_w;
  logic        wb_reg_write, wb_valid, load_fault;
  logic        wb_reg_write_w, wb_valid_w, load_fault_w;
  logic [31:0] wb_data, wb_data_w;
  logic [3:0]  retired4;
  logic [31:0] retired32;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .mem_rdata(mem_rdata),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .wb_valid(wb_valid), .load_fault(load_fault), .retired(retired4)
  );

  mem_wb_stage dut_w (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .mem_rdata(mem_rdata),
    .wb_rd(wb_rd_w), .wb_reg_write(wb_reg_write_w), .wb_data(wb_data_w),
    .wb_valid(wb_valid_w), .load_fault(load_fault_w), .retired(retired32)
  );

  // Model: contents of the WB slot as an instruction record, plus a count.
  bit          m_valid, m_rw;
  bit [4:0]    m_rd;
  bit [1:0]    m_sel;
  bit [2:0]    m_f3;
  bit [31:0]   m_alu, m_pc4, m_imm, m_rdata;
  int unsigned m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] sext8(input bit [31:0] b);
    return (b >= 128) ? b - 256 : b;
  endfunction

  function automatic bit [31:0] sext16(input bit [31:0] h);
    return (h >= 32768) ? h - 65536 : h;
  endfunction

  // Architectural load result; bad=1 for misaligned or unsupported width.
  function automatic bit [31:0] load_result(input bit [2:0] f3, input int off,
                                            input bit [31:0] w, output bit bad);
    bit [31:0] b, h;
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (8 * off)) % 65536;
    bad = 1'b0;
    case (f3)
      3'd0: return sext8(b);
      3'd4: return b;
      3'd1: begin bad = (off % 2 != 0); return sext16(h); end
      3'd5: begin bad = (off % 2 != 0); return h; end
      3'd2: begin bad = (off != 0); return w; end
      default: begin bad = 1'b1; return 0; end
    endcase
  endfunction

  task automatic check_all();
    bit        bad, fault;
    bit [31:0] lv, exp_data;
    lv    = load_result(m_f3, int'(m_alu % 4), m_rdata, bad);
    fault = m_valid && m_sel == 2'd1 && bad;
    case (m_sel)
      2'd0: exp_data = m_alu;
      2'd1: exp_data = fault ? 0 : lv;
      2'd2: exp_data = m_pc4;
      default: exp_data = m_imm;
    endcase
    chk("wb_valid", {31'h0, wb_valid}, {31'h0, m_valid});
    chk("wb_rd", {27'h0, wb_rd}, {27'h0, m_rd});
    chk("load_fault", {31'h0, load_fault}, {31'h0, fault});
    chk("wb_reg_write", {31'h0, wb_reg_write},
        {31'h0, m_valid && m_rw && m_rd != 0 && !fault});
    if (!(m_sel == 2'd1 && !m_valid && bad))
      chk("wb_data", wb_data, exp_data);
    chk("retired4", {28'h0, retired4}, m_ret % 16);
    chk("retired32", retired32, m_ret);
  endtask

  task automatic apply(input bit v, input bit [4:0] rd, input bit rw, input bit [1:0] sel,
                       input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] pc4,
                       input bit [31:0] imm, input bit [31:0] rdata,
                       input bit st, input bit fl);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_wb_sel = sel; in_funct3 = f3;
    in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm; mem_rdata = rdata;
    stall = st; flush = fl;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_alu = 0; m_pc4 = 0; m_imm = 0; m_rdata = 0; m_ret = 0;
  endtask

  // One clock: advance model with the inputs the DUT sampled, then compare.
  task automatic cyc();
    @(posedge clk);
    if (m_valid && !stall) m_ret++;
    if (flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
      m_alu = 0; m_pc4 = 0; m_imm = 0; m_rdata = 0;
    end else if (!stall) begin
      m_valid = in_valid; m_rw = in_reg_write; m_rd = in_rd; m_sel = in_wb_sel;
      m_f3 = in_funct3; m_alu = in_alu_result; m_pc4 = in_pc_plus4;
      m_imm = in_imm; m_rdata = mem_rdata;
    end
    #1;
    check_all();
  endtask

  typedef struct {
    bit [2:0]  f3;
    bit [1:0]  off;
    bit [31:0] exp;
    bit        flt;
  } ld_case_t;

  ld_case_t ld_cases[9] = '{
    '{3'b000, 2'd1, 32'h0000007F, 1'b0},
    '{3'b000, 2'd2, 32'hFFFFFFFF, 1'b0},
    '{3'b100, 2'd3, 32'h00000080, 1'b0},
    '{3'b001, 2'd2, 32'hFFFF80FF, 1'b0},
    '{3'b101, 2'd0, 32'h00007F01, 1'b0},
    '{3'b010, 2'd0, 32'h80FF7F01, 1'b0},
    '{3'b010, 2'd2, 32'h00000000, 1'b1},
    '{3'b001, 2'd3, 32'h00000000, 1'b1},
    '{3'b011, 2'd0, 32'h00000000, 1'b1}
  };

  initial begin
    int unsigned ret_before;
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Fill the stage, then reset asynchronously mid-cycle.
    apply(1, 5'd9, 1, 2'd0, 3'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_load_fault", {31'h0, load_fault}, 32'h0);
    chk("rst_retired", retired32, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Basic ALU writeback and retirement one cycle later.
    apply(1, 5'd5, 1, 2'd0, 3'd0, 32'h1234_5678, 0, 0, 0, 0, 0);
    cyc();
    chk("alu_we", {31'h0, wb_reg_write}, 32'h1);
    chk("alu_rd", {27'h0, wb_rd}, 32'd5);
    chk("alu_data", wb_data, 32'h1234_5678);
    apply(0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("alu_retired", retired32, 32'd1);

    // Load extraction and fault cases on a fixed memory word.
    foreach (ld_cases[i]) begin
      apply(1, 5'd3, 1, 2'd1, ld_cases[i].f3, 32'h0000_1000 | 32'(ld_cases[i].off),
            0, 0, 32'h80FF_7F01, 0, 0);
      ret_before = m_ret;
      cyc();
      chk("ld_data", wb_data, ld_cases[i].exp);
      chk("ld_fault", {31'h0, load_fault}, {31'h0, ld_cases[i].flt});
      chk("ld_we", {31'h0, wb_reg_write}, {31'h0, !ld_cases[i].flt});
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // x0 destination and non-ALU sources.
    apply(1, 5'd0, 1, 2'd0, 3'd0, 32'h55, 0, 0, 0, 0, 0);
    cyc();
    chk("x0_we", {31'h0, wb_reg_write}, 32'h0);
    apply(1, 5'd1, 1, 2'd2, 3'd0, 0, 32'h104, 0, 0, 0, 0);
    cyc();
    chk("pc4_data", wb_data, 32'h104);
    apply(1, 5'd2, 1, 2'd3, 3'd0, 0, 0, 32'hABCD_E000, 0, 0, 0);
    cyc();
    chk("imm_data", wb_data, 32'hABCD_E000);

    // Stall holds A; flush+stall bubbles without retiring; flush drops capture.
    apply(1, 5'd7, 1, 2'd0, 3'd0, 32'h0000_AAAA, 0, 0, 0, 0, 0);
    cyc();
    ret_before = m_ret;
    for (int k = 0; k < 3; k++) begin
      apply(1, 5'd8, 1, 2'd2, 3'd2, $urandom, $urandom, $urandom, $urandom, 1, 0);
      cyc();
      chk("stall_data", wb_data, 32'h0000_AAAA);
      chk("stall_we", {31'h0, wb_reg_write}, 32'h1);
      chk("stall_retired", retired32, ret_before);
    end
    apply(1, 5'd8, 1, 2'd0, 3'd0, 32'h1, 0, 0, 0, 1, 1);
    cyc();
    chk("flst_valid", {31'h0, wb_valid}, 32'h0);
    chk("flst_retired", retired32, ret_before);
    apply(1, 5'd8, 1, 2'd0, 3'd0, 32'h1, 0, 0, 0, 0, 1);
    cyc();
    chk("flush_valid", {31'h0, wb_valid}, 32'h0);
    chk("flush_we", {31'h0, wb_reg_write}, 32'h0);

    // Sixteen retirements bring the 4-bit counter back to its start value.
    ret_before = m_ret;
    for (int k = 0; k < 16; k++) begin
      apply(1, 5'(k + 1), 1, 2'd0, 3'd0, 32'(k), 0, 0, 0, 0, 0);
      cyc();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("wrap_retired4", {28'h0, retired4}, ret_before % 16);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      apply($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 3) != 0,
            2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
